// File: rtl/sram_bist_master.sv
// Power-on SRAM march tester: writes a seeded pattern over every address, then reads it back and verifies.
// Define BIST_INV_PASS_EN to add a second write/read pass using the inverted pattern.
module sram_bist_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  proc_clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH:0]   err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic                  req_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_REL, RD_REQ, RD_REL, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] seed_reg;
  logic                  inv_reg;
  logic [CW-1:0]         phase_cnt_reg;
  logic [ADDR_WIDTH:0]   err_count_reg;
  logic [ADDR_WIDTH-1:0] fail_addr_reg;
  logic [DATA_WIDTH-1:0] fail_data_reg;
  logic                  pass_reg;
  logic                  timeout_reg;

  logic [DATA_WIDTH-1:0] base_pattern, pattern;
  logic last_addr, phase_expired, start_accept, mismatch, timeout_hit, more_passes;
  logic in_req, in_rel;

  assign base_pattern  = seed_reg ^ DATA_WIDTH'(addr_reg);
  assign pattern       = inv_reg ? ~base_pattern : base_pattern;
  assign last_addr     = &addr_reg;
  assign phase_expired = (phase_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign start_accept  = start_i && (state_reg == IDLE || state_reg == DONE);
  assign in_req        = (state_reg == WR_REQ) || (state_reg == RD_REQ);
  assign in_rel        = (state_reg == WR_REL) || (state_reg == RD_REL);
  assign mismatch      = (state_reg == RD_REQ) && ack_i && (rdata_i != pattern);
  // A phase times out when the awaited ack edge has not arrived within the budget.
  assign timeout_hit   = phase_expired && ((in_req && !ack_i) || (in_rel && ack_i));

`ifdef BIST_INV_PASS_EN
  assign more_passes = !inv_reg;
`else
  assign more_passes = 1'b0;
`endif

  always_ff @(posedge proc_clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start_i) state_next = WR_REQ;
      WR_REQ: begin
        if (ack_i)              state_next = WR_REL;
        else if (phase_expired) state_next = DONE;
      end
      WR_REL: begin
        if (!ack_i)             state_next = last_addr ? RD_REQ : WR_REQ;
        else if (phase_expired) state_next = DONE;
      end
      RD_REQ: begin
        if (ack_i)              state_next = RD_REL;
        else if (phase_expired) state_next = DONE;
      end
      RD_REL: begin
        if (!ack_i)             state_next = last_addr ? (more_passes ? WR_REQ : DONE) : RD_REQ;
        else if (phase_expired) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_reg != IDLE) && (state_reg != DONE);
    done_o  = (state_reg == DONE);
    req_o   = in_req;
    wr_en_o = (state_reg == WR_REQ);
    addr_o  = addr_reg;
    wdata_o = (state_reg == WR_REQ) ? pattern : '0;
  end

  always_ff @(posedge proc_clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= '0;
      seed_reg      <= '0;
      inv_reg       <= 1'b0;
      phase_cnt_reg <= '0;
      err_count_reg <= '0;
      fail_addr_reg <= '0;
      fail_data_reg <= '0;
      pass_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      if (state_next != state_reg || !(in_req || in_rel)) phase_cnt_reg <= '0;
      else                                                 phase_cnt_reg <= phase_cnt_reg + CW'(1);

      if (start_accept) begin
        seed_reg      <= seed_i;
        addr_reg      <= '0;
        inv_reg       <= 1'b0;
        err_count_reg <= '0;
        fail_addr_reg <= '0;
        fail_data_reg <= '0;
        pass_reg      <= 1'b0;
        timeout_reg   <= 1'b0;
      end else begin
        // Incrementing past all-ones wraps to 0, which is exactly the pass boundary.
        if (in_rel && !ack_i) begin
          addr_reg <= addr_reg + 1'b1;
          if (state_reg == RD_REL && last_addr && more_passes) inv_reg <= 1'b1;
        end
        if (mismatch) begin
          if (err_count_reg == '0) begin
            fail_addr_reg <= addr_reg;
            fail_data_reg <= rdata_i;
          end
          if (!(&err_count_reg)) err_count_reg <= err_count_reg + 1'b1;
        end
        if (timeout_hit) timeout_reg <= 1'b1;
        if (state_next == DONE && state_reg != DONE)
          pass_reg <= (err_count_reg == '0) && !timeout_hit;
      end
    end
  end

  assign pass_o      = pass_reg;
  assign timeout_o   = timeout_reg;
  assign err_count_o = err_count_reg;
  assign fail_addr_o = fail_addr_reg;
  assign fail_data_o = fail_data_reg;

endmodule

// File: tb/tb_sram_bist_master.sv
// Scoreboard bench for sram_bist_master: stimulus queues expected end-of-run results,
// a negedge monitor pops them when done_o rises and also checks handshake stability.
module tb_sram_bist_master;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 8;
`ifdef BIST_INV_PASS_EN
  localparam bit INV = 1'b1;
  localparam int NT  = 64;
`else
  localparam bit INV = 1'b0;
  localparam int NT  = 32;
`endif

  logic          proc_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] seed_i = '0;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [AW:0]   err_count_o;
  logic [AW-1:0] fail_addr_o;
  logic [DW-1:0] fail_data_o;
  logic          req_o, wr_en_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          ack_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;

  sram_bist_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .proc_clk(proc_clk), .rst(rst), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o), .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .req_o(req_o), .wr_en_o(wr_en_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ack_i(ack_i), .rdata_i(rdata_i)
  );

  always #5 proc_clk = ~proc_clk;

  // Behavioural responder: ack two cycles after req rises, drop ack after req falls.
  logic [DW-1:0] mem [16];
  logic          no_ack = 1'b0;
  logic          corrupt = 1'b0;
  int            rcnt = 0;

  always @(posedge proc_clk) begin
    if (!req_o) begin
      ack_i <= 1'b0;
      rcnt  <= 0;
    end else if (rcnt < 1) begin
      rcnt <= rcnt + 1;
    end else if (!no_ack && !ack_i) begin
      ack_i <= 1'b1;
      if (wr_en_o) mem[addr_o] <= wdata_o;
      else rdata_i <= (corrupt && addr_o == 4'h3) ? (mem[addr_o] & 16'hFFFE) : mem[addr_o];
    end
  end

  typedef struct {
    int          txns;
    logic        pass;
    logic        tmo;
    logic [AW:0] err;
    logic [3:0]  fa;
    logic [15:0] fd;
    logic [3:0]  wa;
    logic [15:0] wd;
    int          rlen;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req_v);
    end
  endtask

  // Monitor
  int          txns = 0;
  int          rlen = 0;
  int          last_rlen = 0;
  logic        req_prev = 1'b0, done_prev = 1'b0, busy_prev = 1'b0;
  logic [3:0]  a_hold;
  logic [15:0] d_hold;
  logic        w_hold;
  logic        stable = 1'b1;
  logic [15:0] last_wr [16];

  always @(negedge proc_clk) begin
    if (busy_o && !busy_prev) txns = 0;
    if (req_o && !req_prev) begin
      txns++;
      rlen   = 0;
      a_hold = addr_o;
      d_hold = wdata_o;
      w_hold = wr_en_o;
      stable = 1'b1;
      if (wr_en_o) last_wr[addr_o] = wdata_o;
    end
    if (req_o) begin
      rlen++;
      if ({addr_o, wdata_o, wr_en_o} != {a_hold, d_hold, w_hold}) stable = 1'b0;
    end
    if (!req_o && req_prev) begin
      last_rlen = rlen;
      chk("req_stable", stable, 1);
    end
    if (done_o && !done_prev) begin
      chk("exp_queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("txn_count", txns, e.txns);
        chk("pass", pass_o, e.pass);
        chk("timeout", timeout_o, e.tmo);
        chk("err_count", err_count_o, e.err);
        chk("fail_addr", fail_addr_o, e.fa);
        chk("fail_data", fail_data_o, e.fd);
        chk("watch_wdata", last_wr[e.wa], e.wd);
        chk("req_high_cycles", last_rlen, e.rlen);
        $display("run done: txns=%0d pass=%0b tmo=%0b err=%0d fail_addr=%0h fail_data=%0h",
                 txns, pass_o, timeout_o, err_count_o, fail_addr_o, fail_data_o);
      end
    end
    req_prev  = req_o;
    done_prev = done_o;
    busy_prev = busy_o;
  end

  task automatic push_exp(input int n, input logic p, input logic t, input int er,
                          input logic [3:0] fa, input logic [15:0] fd,
                          input logic [3:0] wa, input logic [15:0] wd, input int rl);
    exp_t x;
    x.txns = n; x.pass = p; x.tmo = t; x.err = (AW+1)'(er); x.fa = fa; x.fd = fd;
    x.wa = wa; x.wd = wd; x.rlen = rl;
    exp_q.push_back(x);
  endtask

  task automatic start_pulse(input logic [15:0] s);
    @(negedge proc_clk);
    seed_i  = s;
    start_i = 1'b1;
    @(negedge proc_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge proc_clk);
      n++;
    end
    chk("done_within_budget", done_o, 1);
    repeat (2) @(negedge proc_clk);
  endtask

  initial begin
    repeat (3) @(negedge proc_clk);
    chk("reset_outputs",
        {busy_o, done_o, pass_o, timeout_o, err_count_o, fail_addr_o, fail_data_o,
         req_o, wr_en_o, addr_o, wdata_o}, 0);
    rst = 1'b0;

    // 1: ideal memory, seed 0
    push_exp(NT, 1, 0, 0, 4'h0, 16'h0000, 4'h5, INV ? 16'hFFFA : 16'h0005, 3);
    start_pulse(16'h0000);
    wait_done(1500);

    // 2: bit 0 stuck low at address 3
    corrupt = 1'b1;
    push_exp(NT, 0, 0, 1, 4'h3, 16'h0002, 4'h3, INV ? 16'hFFFC : 16'h0003, 3);
    start_pulse(16'h0000);
    wait_done(1500);
    corrupt = 1'b0;

    // 3: responder never acks
    no_ack = 1'b1;
    push_exp(1, 0, 1, 0, 4'h0, 16'h0000, 4'h0, 16'h1234, TO);
    start_pulse(16'h1234);
    wait_done(200);
    no_ack = 1'b0;

    // 4: mid-test start ignored, then rerun with seed FFFF
    push_exp(NT, 1, 0, 0, 4'h0, 16'h0000, 4'h7, INV ? 16'hFFF8 : 16'h0007, 3);
    start_pulse(16'h0000);
    repeat (40) @(negedge proc_clk);
    start_pulse(16'hAAAA);
    wait_done(1500);
    push_exp(NT, 1, 0, 0, 4'h0, 16'h0000, 4'h1, INV ? 16'h0001 : 16'hFFFE, 3);
    start_pulse(16'hFFFF);
    chk("done_cleared_on_start", done_o, 0);
    wait_done(1500);

    // 5: reset during the read pass, then a clean run
    start_pulse(16'h0000);
    begin
      int n = 0;
      while (!(req_o && !wr_en_o) && n < 500) begin
        @(negedge proc_clk);
        n++;
      end
    end
    chk("reached_read_pass", req_o && !wr_en_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {busy_o, done_o, pass_o, timeout_o, err_count_o, fail_addr_o, fail_data_o,
         req_o, wr_en_o, addr_o, wdata_o}, 0);
    repeat (2) @(negedge proc_clk);
    rst = 1'b0;
    push_exp(NT, 1, 0, 0, 4'h0, 16'h0000, 4'h9, INV ? 16'hFEF7 : 16'h0108, 3);
    start_pulse(16'h0101);
    wait_done(1500);

`ifdef BIST_INV_PASS_EN
    // 6: inverted second pass
    push_exp(64, 1, 0, 0, 4'h0, 16'h0000, 4'h2, 16'hFF0D, 3);
    start_pulse(16'h00F0);
    wait_done(1500);
`endif

    chk("all_runs_reported", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
